// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter. Runs the inhibit/request-to-send
// handshake, shifts {parity, data} out on device clocks, checks the ACK and enforces timeouts.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int START_TIMEOUT  = 150000,
    parameter int PACKET_TIMEOUT = 20000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);
    localparam int TW = $clog2(START_TIMEOUT + PACKET_TIMEOUT + INHIBIT_CYCLES + 2);
    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LIM = TW'(START_TIMEOUT);
    localparam logic [TW-1:0] PKT_LIM   = TW'(PACKET_TIMEOUT);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE, ERR, DONE} state_e;

    state_e        state_q, state_d;
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    logic [8:0]    sh_q, sh_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          data_oe_q, data_oe_d;
    logic          err_q, err_d;
    logic          clk_s, dat_s, fe;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fe    = clk_prev_q & ~clk_s;

    // Sync flops reset high (idle bus) so leaving reset never fakes a falling edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clock_in};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
            clk_prev_q <= clk_s;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        data_oe_d = data_oe_q;
        err_d     = err_q;
        // Shifting ones in behind the payload makes edge 10 present the released stop bit.
        if ((state_q == REQ || state_q == SEND) && fe) begin
            cnt_d     = cnt_q + 4'd1;
            data_oe_d = ~sh_q[0];
            sh_d      = {1'b1, sh_q[8:1]};
        end
        case (state_q)
            IDLE: if (tx_start) begin
                state_d   = INHIBIT;
                sh_d      = {~^tx_data, tx_data};
                cnt_d     = '0;
                data_oe_d = 1'b1;
                err_d     = 1'b0;
            end
            INHIBIT:   if (timer_q == INH_LAST) state_d = REQ;
            REQ:       if (fe) state_d = SEND;
                       else if (timer_q > START_LIM) state_d = ERR;
            SEND:      if (fe && cnt_q == 4'd10) state_d = dat_s ? ERR : WAIT_IDLE;
                       else if (timer_q > PKT_LIM) state_d = ERR;
            WAIT_IDLE: if (clk_s && dat_s) state_d = DONE;
                       else if (timer_q > PKT_LIM) state_d = ERR;
            ERR: begin
                state_d = DONE;
                err_d   = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + TW'(1);
    end

    always_comb begin
        tx_busy      = state_q != IDLE;
        tx_done      = state_q == DONE;
        tx_error     = tx_done & err_q;
        ps2_clock_oe = state_q == INHIBIT;
        ps2_data_oe  = (state_q == INHIBIT) ? (timer_q == INH_LAST)
                     : (state_q == REQ || state_q == SEND) & data_oe_q;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: open-drain PS/2 device model plus scoreboard of expected frames and
// expected tx_error values for ps2_host_tx.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int H  = 100;
    localparam int ST = 2000;

    logic clock = 1'b0, resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_start = 1'b0;
    logic tx_busy, tx_done, tx_error, ps2_clock_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
    wire  ps2_clock_in = ~(ps2_clock_oe | dev_clk_low);
    wire  ps2_data_in  = ~(ps2_data_oe | dev_dat_low);
    int   n_cmp = 0, n_err = 0, done_cnt = 0;
    logic [10:0] exp_fr_q[$];
    logic        exp_err_q[$];

    always #50 clock = ~clock;

    ps2_host_tx #(.INHIBIT_CYCLES(1200), .START_TIMEOUT(ST), .PACKET_TIMEOUT(20000)) dut (
        .clock(clock), .resetn(resetn), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
        .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) if (tx_done) begin
        done_cnt++;
        check("done_expected", 32'(exp_err_q.size() != 0), 32'd1);
        if (exp_err_q.size() != 0) check("tx_error", 32'(tx_error), 32'(exp_err_q.pop_front()));
    end

    task automatic send(input logic [7:0] d, input bit err, input bit push_fr, input bit push_err);
        tx_data  = d;
        tx_start = 1'b1;
        if (push_fr) exp_fr_q.push_back({1'b1, ~^d, d, 1'b0});
        if (push_err) exp_err_q.push_back(err);
        @(negedge clock);
        tx_start = 1'b0;
        check("busy_rise", 32'(tx_busy), 32'd1);
        check("clk_oe_rise", 32'(ps2_clock_oe), 32'd1);
    endtask

    task automatic wait_release(output int len, output int ovl);
        int t = 0;
        len = 0;
        ovl = 0;
        while (!ps2_clock_oe && t < 5000) begin @(negedge clock); t++; end
        while (ps2_clock_oe && len < 5000) begin
            ovl += int'(ps2_data_oe);
            @(negedge clock);
            len++;
        end
    endtask

    task automatic dev_frame(input bit ack, output logic [10:0] fr);
        repeat (20) @(negedge clock);
        fr[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            fr[i] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clock);
        end
        dev_dat_low = ack;
        repeat (5) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clock);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (!tx_done && k < budget) begin @(negedge clock); k++; end
        check("done_seen", 32'(tx_done), 32'd1);
        check("busy_at_done", 32'(tx_busy), 32'd1);
        check("oe_at_done", 32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
        @(negedge clock);
        check("busy_after_done", 32'(tx_busy), 32'd0);
    endtask

    task automatic frame_chk(input logic [10:0] fr);
        check("frame_pending", 32'(exp_fr_q.size() != 0), 32'd1);
        if (exp_fr_q.size() != 0) check("frame", 32'(fr), 32'(exp_fr_q.pop_front()));
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack);
        logic [10:0] fr;
        int len, ovl, k;
        send(d, !ack, 1'b1, 1'b1);
        wait_release(len, ovl);
        check("inhibit_len", len, 1200);
        check("rts_overlap", ovl, 1);
        check("start_bit_drive", 32'(ps2_data_oe), 32'd1);
        fork
            dev_frame(ack, fr);
            wait_done(20000, k);
        join
        frame_chk(fr);
    endtask

    initial begin
        logic [10:0] fr;
        int len, ovl, k, d0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        check("rst_clk_oe", 32'(ps2_clock_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        xfer(8'hF4, 1'b1);
        xfer(8'hED, 1'b1);
        xfer(8'h00, 1'b1);

        send(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_release(len, ovl);
        wait_done(ST + 100, k);
        check("timeout_latency", k, ST + 3);

        xfer(8'h3C, 1'b0);

        d0 = done_cnt;
        send(8'hFF, 1'b0, 1'b1, 1'b1);
        wait_release(len, ovl);
        fork
            dev_frame(1'b1, fr);
            begin
                repeat (600) @(negedge clock);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
            end
            wait_done(20000, k);
        join
        frame_chk(fr);
        repeat (20) @(negedge clock);
        check("one_done", done_cnt - d0, 1);

        d0 = done_cnt;
        send(8'h00, 1'b0, 1'b0, 1'b0);
        wait_release(len, ovl);
        repeat (20) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clock);
        end
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clock);
        check("bit4_drive", 32'(ps2_data_oe), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("arst_busy", 32'(tx_busy), 32'd0);
        check("arst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("arst_clk_oe", 32'(ps2_clock_oe), 32'd0);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        repeat (50) @(negedge clock);
        check("no_done_on_reset", done_cnt - d0, 0);

        xfer(8'hF4, 1'b1);
        repeat (10) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
